approx_mul_ha_accum: RTL



---
 rtl/approx_mul_ha_accum_if.sv | 39 +++
 rtl/approx_mul_ha_accum.sv | 120 ++++++++++++
 2 files changed

// File: rtl/approx_mul_ha_accum_if.sv
// Bundle between the approximate multiplier's HA array and its accumulate stage.
// Upstream drives the row set and result-ready signal. The accumulate stage
// drives in_ready and the result signals.
interface approx_mul_ha_accum_if #(
  parameter int OUT_W = 16,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       ha_array_0_b;
  logic [6:0]       ha_array_1_b;
  logic [6:0]       ha_array_2_b;
  logic [6:0]       ha_array_3_b;
  logic [8:0]       ha_array_0_t;
  logic [8:0]       ha_array_1_t;
  logic [8:0]       ha_array_2_t;
  logic [8:0]       ha_array_3_t;
  logic             in_acc;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_prod;
  logic [ACC_W-1:0] out_acc;
  logic             out_acc_sat;

  modport master (
    output in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
           ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           in_acc, in_clr, out_ready,
    input  in_ready, out_valid, out_prod, out_acc, out_acc_sat
  );

  modport slave (
    input  in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
           ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           in_acc, in_clr, out_ready,
    output in_ready, out_valid, out_prod, out_acc, out_acc_sat
  );
endinterface

// File: rtl/approx_mul_ha_accum.sv
// Final sum stage of the 8x8 approximate multiplier.
// The four HA rows are folded in two pipeline stages into the product, and the
// product can optionally be added into a saturating accumulator. The stages
// use a valid/ready handshake with no skid buffer.
module approx_mul_ha_accum #(
  parameter int OUT_W = 16,
  parameter int ACC_W = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  approx_mul_ha_accum_if.slave bus
);
  // Partial sums can reach 5095 (1019 + 4*1019), so they need 13 bits.
  localparam int SUM_W  = 13;
  localparam int WIDE_W = (OUT_W > SUM_W + 4) ? OUT_W : SUM_W + 4;

  typedef struct packed {
    logic [SUM_W-1:0] lo;
    logic [SUM_W-1:0] hi;
    logic             acc;
    logic             clr;
  } s1_t;

  logic [9:0]       row0, row1, row2, row3;
  s1_t              s1_d, s1_q;
  logic             s1_valid_d, s1_valid_q;
  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] prod_w, prod_d, prod_q;
  logic [ACC_W-1:0] acc_base, acc_d, acc_q;
  logic [ACC_W:0]   acc_sum;
  logic             sat_d, sat_q;
  logic             clamp;
  logic             s2_adv, s1_adv, in_ready, accept;

  // Weight each row, then pair rows 0/1 and rows 2/3 into the stage-1 payload.
  always_comb begin
    row0     = 10'(bus.ha_array_0_t) + {1'b0, bus.ha_array_0_b, 2'b00};
    row1     = 10'(bus.ha_array_1_t) + {1'b0, bus.ha_array_1_b, 2'b00};
    row2     = 10'(bus.ha_array_2_t) + {1'b0, bus.ha_array_2_b, 2'b00};
    row3     = 10'(bus.ha_array_3_t) + {1'b0, bus.ha_array_3_b, 2'b00};
    s1_d.lo  = 13'(row0) + {1'b0, row1, 2'b00};
    s1_d.hi  = 13'(row2) + {1'b0, row3, 2'b00};
    s1_d.acc = bus.in_acc;
    s1_d.clr = bus.in_clr;
  end

  // Stage 2 drains whenever it is empty or being consumed. Stage 1 follows it.
  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = bus.in_valid && in_ready;

  // Next-state logic for the valids, the product and the saturating accumulator.
  always_comb begin
    // NOTE: every variable of this block gets a default first so that no path can infer a latch.
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    clamp       = 1'b0;
    prod_w      = OUT_W'(WIDE_W'(s1_q.lo) + (WIDE_W'(s1_q.hi) << 4));
    acc_base    = s1_q.clr ? '0 : acc_q;
    acc_sum     = {1'b0, acc_base} + {{(ACC_W + 1 - OUT_W){1'b0}}, prod_w};

    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end

    if (s1_adv) begin
      prod_d = prod_w;
      if (s1_q.acc) begin
        clamp = acc_sum[ACC_W];
        acc_d = clamp ? '1 : acc_sum[ACC_W-1:0];
      end else begin
        acc_d = acc_base;
      end
      // A clear drops the sticky flag before this load can set it again.
      sat_d = (s1_q.clr ? 1'b0 : sat_q) | clamp;
    end
  end

  // Control and result registers. A reset discards anything in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  // Stage-1 payload register. It loads only on an accepted row set.
  always_ff @(posedge clk) begin
    // NOTE: this payload has no reset. s1_valid_q qualifies it, so stale contents are never used.
    if (accept) begin
      s1_q <= s1_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_prod    = prod_q;
  assign bus.out_acc     = acc_q;
  assign bus.out_acc_sat = sat_q;
endmodule
